// File: rtl/dmem_access_ctrl_if.sv
// Data-memory port bundle between the access controller (master) and the memory (slave).
interface dmem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Sequences EX/MEM loads/stores onto a variable-latency data memory, stalling the
// pipeline while an access is outstanding and flagging misaligned or timed-out accesses.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    dmem_access_ctrl_if.master   dmem,
    output logic                 stall,
    output logic [DATA_W-1:0]    rdata,
    output logic                 load_done,
    output logic                 misalign_err,
    output logic                 timeout_err
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             acc;
    logic             aligned;

    assign acc     = mem_read | mem_write;
    assign aligned = (addr[1:0] == 2'b00);

    // Pipeline is released during reset so nothing stays frozen on a stale request.
    assign stall = reset & (((state == IDLE) & acc & aligned) | (state == BUSY));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            dmem.req     <= 1'b0;
            dmem.we      <= 1'b0;
            dmem.addr    <= '0;
            dmem.wdata   <= '0;
            rdata        <= '0;
            load_done    <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            load_done    <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (aligned) begin
                            dmem.req   <= 1'b1;
                            dmem.we    <= mem_write;
                            dmem.addr  <= addr;
                            dmem.wdata <= wdata;
                            cnt        <= '0;
                            state      <= BUSY;
                        end else begin
                            misalign_err <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    // A completion in the last allowed cycle still wins over the abort.
                    if (dmem.ready) begin
                        dmem.req <= 1'b0;
                        if (!dmem.we) begin
                            rdata     <= dmem.rdata;
                            load_done <= 1'b1;
                        end
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        dmem.req    <= 1'b0;
                        rdata       <= '0;
                        timeout_err <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
